// File: rtl/ibex_id_multicycle_seq.sv
// ibex_id_multicycle_seq: ID-stage multicycle sequencer; define IBEX_ID_SEQ_TIMEOUT_EN to add the watchdog.
module ibex_id_multicycle_seq #(
    parameter int unsigned StallCntW     = 16,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    input  logic [1:0]           instr_kind_i,
    input  logic                 flush_i,
    input  logic                 ex_valid_i,
    input  logic                 lsu_req_done_i,
    input  logic                 lsu_resp_valid_i,
    input  logic                 wb_ready_i,
    output logic                 instr_first_cycle_o,
    output logic                 ex_start_o,
    output logic                 id_in_ready_o,
    output logic                 instr_done_o,
    output logic                 stall_mem_o,
    output logic                 stall_multdiv_o,
    output logic [StallCntW-1:0] stall_cnt_o,
    output logic                 timeout_o
);
    typedef enum logic [1:0] {IDLE, EXEC, LSU_REQ, LSU_RESP} state_e;
    if (TimeoutCycles == 0 || TimeoutCycles > 65535) begin : g_bad_timeout
        $error("TimeoutCycles out of range");
    end
    state_e               r_state, w_next;
    logic                 r_drain, w_drain_next;
    logic [StallCntW-1:0] r_stall_cnt;
    logic w_idle, w_accept, w_valid, w_single, w_ex_done, w_req_retire, w_resp_done, w_retire, w_stall;
    assign w_idle       = r_state == IDLE;
    assign w_accept     = w_idle & ~r_drain;
    assign w_valid      = w_accept & instr_valid_i;
    assign w_single     = w_valid & (instr_kind_i == 2'd0);
    assign w_ex_done    = (r_state == EXEC) & ex_valid_i & wb_ready_i;
    assign w_req_retire = (r_state == LSU_REQ) & lsu_req_done_i & lsu_resp_valid_i & wb_ready_i;
    assign w_resp_done  = (r_state == LSU_RESP) & lsu_resp_valid_i & wb_ready_i;
    assign w_retire     = (w_single & wb_ready_i) | w_ex_done | w_req_retire | w_resp_done;
    assign instr_first_cycle_o = w_valid;
    assign instr_done_o        = w_retire & ~flush_i & ~rst_i;
    assign ex_start_o          = w_valid & (instr_kind_i != 2'd0) & ~flush_i & ~rst_i;
    assign id_in_ready_o       = instr_done_o | (w_accept & ~instr_valid_i);
    assign stall_multdiv_o     = (r_state == EXEC) & ~w_ex_done;
    // The request-handshake cycle always counts as a memory stall, even on a same-cycle response.
    assign stall_mem_o = (r_state == LSU_REQ) | ((r_state == LSU_RESP) & ~w_resp_done) |
                         (r_drain & ~lsu_resp_valid_i);
    assign w_stall     = stall_mem_o | stall_multdiv_o | (w_single & ~wb_ready_i & ~flush_i);
    assign stall_cnt_o = r_stall_cnt;
    always_comb begin
        w_next       = r_state;
        w_drain_next = r_drain & ~lsu_resp_valid_i;
        unique case (r_state)
            IDLE:     w_next = ex_start_o ? (instr_kind_i == 2'd2 ? LSU_REQ : EXEC) : IDLE;
            EXEC:     w_next = w_ex_done ? IDLE : EXEC;
            LSU_REQ:  w_next = lsu_req_done_i ? (w_req_retire ? IDLE : LSU_RESP) : LSU_REQ;
            LSU_RESP: w_next = w_resp_done ? IDLE : LSU_RESP;
        endcase
        if (flush_i) begin
            w_next = IDLE;
            if (r_state == LSU_REQ || r_state == LSU_RESP) w_drain_next = ~lsu_resp_valid_i;
        end
    end
`ifdef IBEX_ID_SEQ_TIMEOUT_EN
    logic [15:0] r_wd_cnt;
    logic        r_timeout;
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_drain     <= 1'b0;
            r_stall_cnt <= '0;
`ifdef IBEX_ID_SEQ_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_drain <= w_drain_next;
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + StallCntW'(1);
`ifdef IBEX_ID_SEQ_TIMEOUT_EN
            if (w_idle) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt == 16'(TimeoutCycles - 1)) begin
                r_wd_cnt  <= '0;
                r_timeout <= 1'b1;
                r_state   <= IDLE;
            end else begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
`endif
        end
    end
endmodule

// File: doc/ibex_id_multicycle_seq.md
IBEX_ID_MULTICYCLE_SEQ -- requirements
Module: ibex_id_multicycle_seq

Interface
REQ-001 Parameter StallCntW, default 16: width of the stall-cycle counter.
REQ-002 Parameter TimeoutCycles, default 255: watchdog limit in cycles; legal range 1..65535.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 instr_valid_i  in  1  ID holds a valid instruction.
REQ-006 instr_kind_i  in  2  instruction class: 0 single-cycle, 1 multdiv, 2 load/store, 3 multicycle ALU.
REQ-007 flush_i  in  1  kill the instruction in ID (exception, branch, debug).
REQ-008 ex_valid_i  in  1  EX multicycle unit result valid.
REQ-009 lsu_req_done_i  in  1  LSU accepted the data request.
REQ-010 lsu_resp_valid_i  in  1  LSU response valid.
REQ-011 wb_ready_i  in  1  writeback can accept an instruction.
REQ-012 instr_first_cycle_o  out  1  first cycle of the instruction in ID.
REQ-013 ex_start_o  out  1  one-cycle start pulse to EX or LSU.
REQ-014 id_in_ready_o  out  1  ID accepts the next instruction next cycle.
REQ-015 instr_done_o  out  1  one-cycle retire pulse.
REQ-016 stall_mem_o / stall_multdiv_o  out  1 each  waiting on LSU / on multdiv or ALU.
REQ-017 stall_cnt_o  out  StallCntW  saturating count of stall cycles.
REQ-018 timeout_o  out  1  sticky watchdog flag.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, LSU_REQ, LSU_RESP.
REQ-020 instr_first_cycle_o SHALL be 1 in IDLE with instr_valid_i=1 and 0 otherwise.
REQ-021 IDLE with valid and kind 0 SHALL assert instr_done_o and id_in_ready_o the same cycle when wb_ready_i=1, and stay in IDLE.
REQ-022 IDLE with valid and kind 0 and wb_ready_i=0 SHALL hold: no done pulse, id_in_ready_o=0, and a stall counted.
REQ-023 IDLE with valid and kind 1 or 3 SHALL pulse ex_start_o and go to EX.
REQ-024 IDLE with valid and kind 2 SHALL pulse ex_start_o and go to LSU_REQ.
REQ-025 EX SHALL go to IDLE with instr_done_o=1 on ex_valid_i AND wb_ready_i; otherwise it stays with stall_multdiv_o=1.
REQ-026 LSU_REQ SHALL go to LSU_RESP on lsu_req_done_i with stall_mem_o=1 meanwhile.
REQ-027 If lsu_req_done_i and lsu_resp_valid_i coincide in LSU_REQ, the FSM SHALL retire directly to IDLE.
REQ-028 LSU_RESP SHALL go to IDLE with instr_done_o=1 on lsu_resp_valid_i AND wb_ready_i.
REQ-029 id_in_ready_o SHALL equal instr_done_o OR (IDLE AND NOT instr_valid_i).
REQ-030 flush_i SHALL force IDLE next cycle from any state and suppress instr_done_o and ex_start_o that cycle.
REQ-031 flush_i in LSU_REQ or LSU_RESP SHALL still wait for lsu_resp_valid_i before accepting (drain); id_in_ready_o=0 until then.
REQ-032 Each cycle with any stall output high, or the REQ-022 condition, SHALL increment stall_cnt_o, saturating at all-ones with no wrap.
REQ-033 ex_start_o SHALL never be asserted in two consecutive cycles for one instruction.

Reset
REQ-034 On rst_i high at a clock edge: state IDLE, stall_cnt_o=0, timeout_o=0, drain flag=0.
REQ-035 All pulse outputs SHALL be 0 during reset, including reset asserted mid-operation.

Configuration
REQ-036 Macro IBEX_ID_SEQ_TIMEOUT_EN defined: a 16-bit counter SHALL count cycles in a non-IDLE state; reaching TimeoutCycles SHALL set timeout_o (sticky until reset) and force IDLE.
REQ-037 Macro undefined: no watchdog counter is instantiated and timeout_o SHALL be tied to 0.

Verification
REQ-038 Kind 0, valid, wb_ready=1 -> instr_first_cycle_o=1, instr_done_o=1 same cycle, stall_cnt_o stays 0.
REQ-039 Kind 1, ex_valid_i 4 cycles after start -> ex_start_o pulse once, stall_multdiv_o=1 for 4 cycles, stall_cnt_o=4, done on cycle 5.
REQ-040 Kind 2, lsu_req_done_i and lsu_resp_valid_i in the same cycle -> direct retire to IDLE, stall_cnt_o=1.
REQ-041 Kind 2, flush_i in LSU_RESP, response 3 cycles later -> no instr_done_o, id_in_ready_o=0 until the response arrives.
REQ-042 StallCntW=4, stall for 20 cycles -> stall_cnt_o saturates at 15.
REQ-043 With IBEX_ID_SEQ_TIMEOUT_EN and TimeoutCycles=8, kind 1 with no ex_valid_i -> timeout_o=1 after 8 cycles, state IDLE; rst_i clears it.
